// File: rtl/stage_control.sv
// stage_control: five-stage instruction strobe sequencer with retire counter
//
// Ports:
//   Clock        single clock, rising-edge state updates
//   Reset        synchronous active-high reset
//   ClockCount   current stage number 1..5 from the upstream stage counter
//   Opcode       instruction opcode, sampled at stage 2
//   BranchCond   ALU branch condition, sampled at stage 3
//   IRLoad, PCIncrement                       stage-1 fetch strobes
//   RegRead, ALUEnable, MemRead, MemWrite,
//   RegWrite, PCLoad                          per-stage strobes
//   InstrDone    one-cycle retirement pulse
//   RetireCount  retired-instruction count (COUNT_W bits, wraps)
//   SeqError     sticky stage-sequence error flag
//
// Macro STAGE_SEQ_CHECK_EN: when defined, a stage-sequence violation halts
// in ERROR with SeqError set until Reset; otherwise the block silently
// resynchronises and SeqError stays 0.
module stage_control #(
  parameter int COUNT_W = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [2:0]         ClockCount,
  input  logic [3:0]         Opcode,
  input  logic               BranchCond,
  output logic               IRLoad,
  output logic               PCIncrement,
  output logic               RegRead,
  output logic               ALUEnable,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               PCLoad,
  output logic               InstrDone,
  output logic [COUNT_W-1:0] RetireCount,
  output logic               SeqError
);
  typedef enum logic [1:0] {SYNC, RUN, ERROR} state_t;
  state_t state;
  logic [2:0] prev_cc;
  logic [3:0] op_reg;
  logic taken_reg;
  logic [2:0] next_cc;
  logic go;
  logic violation;
  // go: ClockCount is the stage we may act on this edge
  always_comb begin
    next_cc = (prev_cc == 3'd5) ? 3'd1 : prev_cc + 3'd1;
    go = (state == SYNC) ? (ClockCount == 3'd1) : (state == RUN) && (ClockCount == next_cc);
    violation = (state == RUN) && (ClockCount != next_cc);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= SYNC;
      prev_cc     <= 3'd0;
      op_reg      <= 4'h0;
      taken_reg   <= 1'b0;
      IRLoad      <= 1'b0;
      PCIncrement <= 1'b0;
      RegRead     <= 1'b0;
      ALUEnable   <= 1'b0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      RegWrite    <= 1'b0;
      PCLoad      <= 1'b0;
      InstrDone   <= 1'b0;
      RetireCount <= '0;
      SeqError    <= 1'b0;
    end else begin
      IRLoad      <= go && ClockCount == 3'd1;
      PCIncrement <= go && ClockCount == 3'd1;
      RegRead     <= go && ClockCount == 3'd2;
      ALUEnable   <= go && ClockCount == 3'd3;
      MemRead     <= go && ClockCount == 3'd4 && op_reg == 4'h8;
      MemWrite    <= go && ClockCount == 3'd4 && op_reg == 4'h9;
      RegWrite    <= go && ClockCount == 3'd5 && op_reg <= 4'h8;
      PCLoad      <= go && ClockCount == 3'd5 && op_reg == 4'hA && taken_reg;
      InstrDone   <= go && ClockCount == 3'd5;
      if (go && ClockCount == 3'd5) RetireCount <= RetireCount + COUNT_W'(1);
      if (go && ClockCount == 3'd2) op_reg <= Opcode;
      if (go && ClockCount == 3'd3) taken_reg <= BranchCond;
      if (go) begin
        state   <= RUN;
        prev_cc <= ClockCount;
      end else if (violation) begin
`ifdef STAGE_SEQ_CHECK_EN
        state    <= ERROR;
        SeqError <= 1'b1;
`else
        state    <= SYNC;
`endif
      end
    end
  end
endmodule

// File: tb/tb_stage_control.sv
// tb_stage_control: directed self-checking bench for stage_control with a behavioural model
module tb_stage_control;
  localparam int CW = 4;
  logic Clock = 1'b0;
  logic Reset;
  logic [2:0] ClockCount;
  logic [3:0] Opcode;
  logic BranchCond;
  logic IRLoad, PCIncrement, RegRead, ALUEnable, MemRead, MemWrite, RegWrite, PCLoad, InstrDone;
  logic [CW-1:0] RetireCount;
  logic SeqError;
  int passed = 0;
  int total = 0;
  bit chk_en = 0;
  bit m_run = 0, m_halt = 0, m_tk = 0, m_err = 0;
  int m_last = 0, m_op = 0, m_cnt = 0;
  logic [8:0] m_exp = '0;
  logic [8:0] dut_v;

  stage_control #(.COUNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .ClockCount(ClockCount), .Opcode(Opcode),
    .BranchCond(BranchCond), .IRLoad(IRLoad), .PCIncrement(PCIncrement),
    .RegRead(RegRead), .ALUEnable(ALUEnable), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCLoad(PCLoad),
    .InstrDone(InstrDone), .RetireCount(RetireCount), .SeqError(SeqError)
  );

  always #5 Clock = ~Clock;
  assign dut_v = {IRLoad, PCIncrement, RegRead, ALUEnable, MemRead, MemWrite, RegWrite, PCLoad, InstrDone};

  // Expected strobe set {IRLoad,PCInc,RegRead,ALUEn,MemRd,MemWr,RegWr,PCLoad,Done} for a stage
  function automatic logic [8:0] strobes(int s, int op, bit tk);
    case (s)
      1: return 9'b110000000;
      2: return 9'b001000000;
      3: return 9'b000100000;
      4: return {4'b0000, op == 8, op == 9, 3'b000};
      5: return {6'b000000, op <= 8, op == 10 && tk, 1'b1};
      default: return 9'b0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Behavioural model: tracks the legal stage ring and what each stage must emit
  initial forever begin
    int c;
    bit legal;
    @(posedge Clock);
    if (Reset) begin
      m_run = 0; m_halt = 0; m_last = 0; m_op = 0; m_tk = 0; m_cnt = 0; m_err = 0; m_exp = '0;
    end else begin
      c = int'(ClockCount);
      legal = !m_halt && (m_run ? (c == m_last % 5 + 1) : (c == 1));
      if (legal) begin
        m_exp = strobes(c, m_op, m_tk);
        if (c == 2) m_op = int'(Opcode);
        if (c == 3) m_tk = BranchCond;
        if (c == 5) m_cnt = (m_cnt + 1) % (1 << CW);
        m_run = 1;
        m_last = c;
      end else begin
        m_exp = '0;
        if (m_run) begin
          m_run = 0;
`ifdef STAGE_SEQ_CHECK_EN
          m_halt = 1;
          m_err = 1;
`endif
        end
      end
    end
  end

  always @(negedge Clock) if (chk_en) begin
    check("strobes", 32'(dut_v), 32'(m_exp));
    check("retire", 32'(RetireCount), 32'(m_cnt));
    check("seqerr", 32'(SeqError), 32'(m_err));
  end

  task automatic step(bit r, int c, int o, bit b);
    @(negedge Clock);
    Reset = r;
    ClockCount = c[2:0];
    Opcode = o[3:0];
    BranchCond = b;
    @(posedge Clock);
    #1;
  endtask

  // Garbage opcode/branch values outside their sampling stage catch mis-timed captures
  task automatic instr(int op, bit bc);
    step(0, 1, 15, !bc);
    step(0, 2, op, !bc);
    step(0, 3, 15, bc);
    step(0, 4, 15, !bc);
    step(0, 5, 15, !bc);
  endtask

  initial begin
    int ops[5] = '{0, 7, 11, 15, 5};
    int bad[3] = '{1, 6, 0};
    Reset = 1; ClockCount = 0; Opcode = 0; BranchCond = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_en = 1;
    check("rst_strobes", 32'(dut_v), 0);
    check("rst_retire", 32'(RetireCount), 0);
    check("rst_seqerr", 32'(SeqError), 0);
    step(0, 3, 0, 0);
    check("sync_ignores", 32'(dut_v), 0);
    step(0, 1, 0, 0);
    check("load_s1", 32'(dut_v), 32'h180);
    step(0, 2, 8, 0);
    check("load_s2", 32'(dut_v), 32'h040);
    step(0, 3, 0, 0);
    check("load_s3", 32'(dut_v), 32'h020);
    step(0, 4, 0, 0);
    check("load_s4", 32'(dut_v), 32'h010);
    step(0, 5, 0, 0);
    check("load_s5", 32'(dut_v), 32'h005);
    check("load_retire", 32'(RetireCount), 1);
    check("model_retire", 32'(m_cnt), 1);
    instr(10, 1);
    check("br_taken", 32'(dut_v), 32'h003);
    instr(10, 0);
    check("br_not", 32'(dut_v), 32'h001);
    step(0, 1, 0, 0); step(0, 2, 9, 0); step(0, 3, 0, 0);
    step(0, 4, 0, 0);
    check("store_s4", 32'(dut_v), 32'h008);
    check("model_store_s4", 32'(m_exp), 32'h008);
    step(0, 5, 0, 0);
    check("store_s5", 32'(dut_v), 32'h001);
    foreach (ops[i]) instr(ops[i], 1);
    check("retire9", 32'(RetireCount), 9);
    step(0, 1, 0, 0); step(0, 2, 8, 0);
    step(0, 4, 0, 0);
    check("viol_strobes", 32'(dut_v), 0);
`ifdef STAGE_SEQ_CHECK_EN
    check("viol_seqerr", 32'(SeqError), 1);
    step(0, 5, 0, 0);
    instr(8, 0);
    check("halt_strobes", 32'(dut_v), 0);
    check("halt_retire", 32'(RetireCount), 9);
`else
    check("viol_seqerr", 32'(SeqError), 0);
    instr(0, 0);
    check("resync_s5", 32'(dut_v), 32'h005);
    check("resync_retire", 32'(RetireCount), 10);
`endif
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 2, 8, 0);
    step(1, 3, 0, 0);
    check("midrst_strobes", 32'(dut_v), 0);
    check("midrst_retire", 32'(RetireCount), 0);
    step(0, 4, 0, 0);
    step(0, 5, 0, 0);
    check("midrst_no_done", 32'(dut_v), 0);
    step(0, 1, 0, 0);
    check("midrst_resume", 32'(dut_v), 32'h180);
    step(0, 2, 3, 0); step(0, 3, 0, 0); step(0, 4, 0, 0); step(0, 5, 0, 0);
    check("midrst_retire1", 32'(RetireCount), 1);
    instr(8, 0);
    step(0, 1, 0, 0); step(0, 2, 8, 0); step(0, 3, 0, 0); step(0, 4, 0, 0);
    step(1, 5, 0, 0);
    check("rst_vs_done", 32'(InstrDone), 0);
    check("rst_vs_retire", 32'(RetireCount), 0);
    foreach (bad[i]) begin
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, bad[i], 0, 0);
      check($sformatf("bad_next_%0d", bad[i]), 32'(dut_v), 0);
      step(0, 1, 0, 0);
    end
    step(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) instr(i, i % 2 == 1);
    check("wrap_pre", 32'(RetireCount), 15);
    instr(2, 0);
    check("wrap_zero", 32'(RetireCount), 0);
    check("wrap_done", 32'(InstrDone), 1);
    check("model_wrap", 32'(m_cnt), 0);
    step(0, 1, 0, 0);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
